servo_pwm_driver: RTL and testbench

//  Consumes the signed control word produced by the PID chain (proportional + integral sum) and drives the servo PWM pin.

---
 rtl/servo_pwm_driver_pkg.sv | 32 +++
 rtl/servo_pwm_driver_width_sat.sv | 45 ++++
 rtl/servo_pwm_driver.sv | 130 +++++++++++++
 tb/tb_servo_pwm_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_driver_pkg.sv
// Shared state encoding, default timing and parameter sanity helper
// for the servo PWM output stage.
package servo_pwm_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // 20 ms frame, 1.0/1.5/2.0 ms pulses at 50 MHz
    localparam int DEF_N          = 19;
    localparam int DEF_SHIFT      = 2;
    localparam int DEF_PERIOD_CNT = 1000000;
    localparam int DEF_PULSE_MIN  = 50000;
    localparam int DEF_PULSE_CTR  = 75000;
    localparam int DEF_PULSE_MAX  = 100000;
    localparam int DEF_CW         = 20;

    function automatic bit params_ok(
        input int n,
        input int cw,
        input int period,
        input int pmin,
        input int pctr,
        input int pmax
    );
        return (pmin <= pctr) && (pctr <= pmax) && (pmax < period)
            && (period <= (1 << cw)) && (n <= cw + 2);
    endfunction

endpackage

// File: rtl/servo_pwm_driver_width_sat.sv
// Control word to pulse width: arithmetic shift, centre offset and
// clamp to the legal servo range, with clip flags.
module servo_pwm_driver_width_sat
    import servo_pwm_driver_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int CW        = DEF_CW,
    parameter int PULSE_MIN = DEF_PULSE_MIN,
    parameter int PULSE_CTR = DEF_PULSE_CTR,
    parameter int PULSE_MAX = DEF_PULSE_MAX
) (
    input  logic [N-1:0]  i_u,
    output logic [CW-1:0] o_width,
    output logic          o_sat_hi,
    output logic          o_sat_lo
);

    localparam int SW = CW + 2;
    localparam logic signed [SW-1:0] C_MIN = SW'(PULSE_MIN);
    localparam logic signed [SW-1:0] C_CTR = SW'(PULSE_CTR);
    localparam logic signed [SW-1:0] C_MAX = SW'(PULSE_MAX);

    logic signed [SW-1:0] w_ext;
    logic signed [SW-1:0] w_s;
    logic signed [SW-1:0] w_sum;

    assign w_ext = SW'($signed(i_u));
    assign w_s   = w_ext >>> SHIFT;
    assign w_sum = C_CTR + w_s;

    always_comb begin
        o_width  = w_sum[CW-1:0];
        o_sat_hi = 1'b0;
        o_sat_lo = 1'b0;
        if (w_sum > C_MAX) begin
            o_width  = C_MAX[CW-1:0];
            o_sat_hi = 1'b1;
        end else if (w_sum < C_MIN) begin
            o_width  = C_MIN[CW-1:0];
            o_sat_lo = 1'b1;
        end
    end

endmodule

// File: rtl/servo_pwm_driver.sv
// Servo PWM driver: frame counter, run/drain FSM, double-buffered
// pulse width and per-frame sample tick for the PID controller.
module servo_pwm_driver
    import servo_pwm_driver_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int PERIOD_CNT = DEF_PERIOD_CNT,
    parameter int PULSE_MIN  = DEF_PULSE_MIN,
    parameter int PULSE_CTR  = DEF_PULSE_CTR,
    parameter int PULSE_MAX  = DEF_PULSE_MAX,
    parameter int CW         = DEF_CW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic [N-1:0]  i_u_in,
    input  logic          i_u_valid,
    output logic          o_u_ready,
    output logic          o_sample_tick,
    output logic          o_pwm_out,
    output logic [CW-1:0] o_pulse_width,
    output logic          o_sat_hi,
    output logic          o_sat_lo
);

    if (!params_ok(N, CW, PERIOD_CNT, PULSE_MIN, PULSE_CTR, PULSE_MAX))
    begin : g_param_check
        $error("servo_pwm_driver: inconsistent timing parameters");
    end

    localparam logic [CW-1:0] LAST  = CW'(PERIOD_CNT - 1);
    localparam logic [CW-1:0] CTR_W = CW'(PULSE_CTR);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_shadow_w;
    logic [CW-1:0] r_active_w;
    logic          r_pwm;
    logic          r_sat_hi;
    logic          r_sat_lo;
    logic [CW-1:0] w_sat_width;
    logic          w_sat_hi;
    logic          w_sat_lo;
    logic          w_running;
    logic          w_wrap;
    logic          w_accept;

    servo_pwm_driver_width_sat #(
        .N         (N),
        .SHIFT     (SHIFT),
        .CW        (CW),
        .PULSE_MIN (PULSE_MIN),
        .PULSE_CTR (PULSE_CTR),
        .PULSE_MAX (PULSE_MAX)
    ) u_width_sat (
        .i_u      (i_u_in),
        .o_width  (w_sat_width),
        .o_sat_hi (w_sat_hi),
        .o_sat_lo (w_sat_lo)
    );

    assign w_running = (r_state != ST_IDLE);
    assign w_wrap    = w_running && (r_cnt == LAST);
    assign w_accept  = i_u_valid && o_u_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // DRAIN only releases to IDLE on the last count, so a frame never truncates
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_enable) w_state_nxt = ST_RUN;
            ST_RUN:   if (!i_enable) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (i_enable)          w_state_nxt = ST_RUN;
                else if (r_cnt == LAST) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_u_ready     = 1'b0;
        o_sample_tick = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                o_u_ready     = 1'b1;
                o_sample_tick = (r_cnt == '0);
            end
            ST_DRAIN: o_u_ready = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt      <= '0;
            r_pwm      <= 1'b0;
            r_active_w <= CTR_W;
        end else begin
            r_pwm <= w_running && (r_cnt < r_active_w);
            if (!w_running || w_wrap) r_cnt <= '0;
            else                      r_cnt <= r_cnt + CW'(1);
            if (w_wrap) r_active_w <= r_shadow_w;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_shadow_w <= CTR_W;
            r_sat_hi   <= 1'b0;
            r_sat_lo   <= 1'b0;
        end else if (w_accept) begin
            r_shadow_w <= w_sat_width;
            r_sat_hi   <= w_sat_hi;
            r_sat_lo   <= w_sat_lo;
        end
    end

    assign o_pwm_out     = r_pwm;
    assign o_pulse_width = r_active_w;
    assign o_sat_hi      = r_sat_hi;
    assign o_sat_lo      = r_sat_lo;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver on a shortened frame
// (1200 clocks, pulses 500/750/1000, 11-bit control word).
module tb_servo_pwm_driver;

    localparam int N     = 11;
    localparam int SHIFT = 2;
    localparam int P     = 1200;
    localparam int PMIN  = 500;
    localparam int PCTR  = 750;
    localparam int PMAX  = 1000;
    localparam int CW    = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [N-1:0]  u_in;
    logic          u_valid;
    logic          u_ready;
    logic          sample_tick;
    logic          pwm_out;
    logic [CW-1:0] pulse_width;
    logic          sat_hi;
    logic          sat_lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    servo_pwm_driver #(
        .N          (N),
        .SHIFT      (SHIFT),
        .PERIOD_CNT (P),
        .PULSE_MIN  (PMIN),
        .PULSE_CTR  (PCTR),
        .PULSE_MAX  (PMAX),
        .CW         (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_u_in        (u_in),
        .i_u_valid     (u_valid),
        .o_u_ready     (u_ready),
        .o_sample_tick (sample_tick),
        .o_pwm_out     (pwm_out),
        .o_pulse_width (pulse_width),
        .o_sat_hi      (sat_hi),
        .o_sat_lo      (sat_lo)
    );

    typedef struct {
        int u;
        int w;
        int hi;
        int lo;
    } vec_t;

    vec_t vecs[10];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Runs one frame from its cnt==0 cycle; optional accept at cnt==acc_at
    task automatic run_frame(
        input  int acc_at,
        input  int u,
        input  int mid_exp,
        output int hi,
        output int ticks
    );
        hi    = 0;
        ticks = 0;
        for (int i = 0; i < P; i++) begin
            if (pwm_out) hi++;
            if (sample_tick) ticks++;
            if (i == acc_at) begin
                u_valid = 1'b1;
                u_in    = u[N-1:0];
            end else begin
                u_valid = 1'b0;
            end
            if (acc_at >= 0 && i == acc_at + 2)
                chk("width_mid_frame", int'(pulse_width), mid_exp);
            cyc();
        end
        u_valid = 1'b0;
    endtask

    initial begin
        int hi;
        int ticks;
        int prev;

        vecs[0] = '{400,   850,  0, 0};
        vecs[1] = '{1023,  1000, 1, 0};
        vecs[2] = '{0,     750,  0, 0};
        vecs[3] = '{-1024, 500,  0, 1};
        vecs[4] = '{1000,  1000, 0, 0};
        vecs[5] = '{1004,  1000, 1, 0};
        vecs[6] = '{-1000, 500,  0, 0};
        vecs[7] = '{-1001, 500,  0, 1};
        vecs[8] = '{-3,    749,  0, 0};
        vecs[9] = '{999,   999,  0, 0};

        rst     = 1'b0;
        enable  = 1'b0;
        u_in    = '0;
        u_valid = 1'b0;
        repeat (3) cyc();
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(sample_tick), 0);
        chk("rst_ready", int'(u_ready), 0);
        chk("rst_sat_hi", int'(sat_hi), 0);
        chk("rst_sat_lo", int'(sat_lo), 0);
        chk("rst_width", int'(pulse_width), PCTR);

        rst = 1'b1;
        cyc();
        chk("idle_ready", int'(u_ready), 0);
        chk("idle_tick", int'(sample_tick), 0);

        enable = 1'b1;
        cyc();
        chk("start_tick", int'(sample_tick), 1);
        chk("start_ready", int'(u_ready), 1);
        chk("start_pwm", int'(pwm_out), 0);

        run_frame(-1, 0, 0, hi, ticks);
        chk("f0_width", hi, PCTR);
        chk("f0_ticks", ticks, 1);
        chk("f0_next_tick", int'(sample_tick), 1);

        prev = PCTR;
        for (int k = 0; k < 10; k++) begin
            run_frame(100, vecs[k].u, prev, hi, ticks);
            chk($sformatf("v%0d_cur_frame", k), hi, prev);
            chk($sformatf("v%0d_ticks", k), ticks, 1);
            chk($sformatf("v%0d_wrap_tick", k), int'(sample_tick), 1);
            chk($sformatf("v%0d_pulse_width", k), int'(pulse_width), vecs[k].w);
            chk($sformatf("v%0d_sat_hi", k), int'(sat_hi), vecs[k].hi);
            chk($sformatf("v%0d_sat_lo", k), int'(sat_lo), vecs[k].lo);
            prev = vecs[k].w;
        end

        // accept on the wrap cycle lands one frame late
        run_frame(P - 1, -400, 0, hi, ticks);
        chk("wrapacc_frame", hi, 999);
        chk("wrapacc_width", int'(pulse_width), 999);
        run_frame(-1, 0, 0, hi, ticks);
        chk("wrapacc_next", hi, 999);
        chk("wrapacc_width2", int'(pulse_width), 650);
        run_frame(-1, 0, 0, hi, ticks);
        chk("wrapacc_after", hi, 650);

        hi    = 0;
        ticks = 0;
        for (int i = 0; i < P; i++) begin
            if (pwm_out) hi++;
            if (sample_tick) ticks++;
            if (i == 300) enable = 1'b0;
            if (i == 310) chk("drain_ready", int'(u_ready), 1);
            cyc();
        end
        chk("drain_width", hi, 650);
        chk("drain_ticks", ticks, 1);
        chk("drain_no_tick", int'(sample_tick), 0);
        chk("drain_idle_ready", int'(u_ready), 0);
        hi    = 0;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            if (pwm_out) hi++;
            if (sample_tick) ticks++;
            cyc();
        end
        chk("idle_pwm_high", hi, 0);
        chk("idle_ticks", ticks, 0);

        u_in    = 11'd1023;
        u_valid = 1'b1;
        repeat (3) cyc();
        u_valid = 1'b0;
        chk("ignored_sat_hi", int'(sat_hi), 0);

        enable = 1'b1;
        cyc();
        chk("restart_tick", int'(sample_tick), 1);
        run_frame(-1, 0, 0, hi, ticks);
        chk("restart_frame", hi, 650);
        chk("ignored_width", int'(pulse_width), 650);

        for (int i = 0; i < 400; i++) cyc();
        chk("pre_rst_pwm", int'(pwm_out), 1);
        rst = 1'b0;
        cyc();
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_width", int'(pulse_width), PCTR);
        chk("mid_rst_ready", int'(u_ready), 0);
        chk("mid_rst_tick", int'(sample_tick), 0);
        repeat (2) cyc();
        enable = 1'b0;
        rst    = 1'b1;
        hi     = 0;
        for (int i = 0; i < 50; i++) begin
            if (pwm_out) hi++;
            cyc();
        end
        chk("post_rst_pwm_high", hi, 0);
        chk("post_rst_ready", int'(u_ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
